// File: rtl/signed_div_pow2_pkg.sv
// signed_div_pow2_pkg
// Shared definitions for the signed divide-by-2^S pipeline.
//   DEF_N    : default data width
//   DEF_S    : default divisor exponent (divisor = 2^S)
//   bias_val : bias added to negative dividends before the arithmetic shift.
//              It is 2^S-1 for round-toward-zero and 0 for floor. The caller
//              selects the mode; the top module does so from the macro
//              SIGNED_DIV_POW2_ROUND_ZERO_EN.
package signed_div_pow2_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_S = 3;

    function automatic int bias_val(input int n, input int s, input bit round_zero);
        // An out-of-range exponent gets no bias, so the function never
        // returns a value wider than the data path.
        if (!round_zero || s < 1 || s >= n)
            return 0;
        return (1 << s) - 1;
    endfunction

endpackage

// File: rtl/div_pow2_reg_slice.sv
// div_pow2_reg_slice
// A single valid/ready register stage. The parent computes the load enable.
// The payload changes only when a valid item is loaded, so a stalled output
// stays stable.
//   clk       : clock
//   rst_n     : asynchronous active-low reset; clears valid and data
//   load      : stage may take a new item this cycle (it may also go empty)
//   src_valid : upstream item present
//   src_data  : upstream payload, W bits
//   valid     : stage holds an item
//   data      : registered payload, W bits
module div_pow2_reg_slice #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         src_valid,
    input  logic [W-1:0] src_data,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid)
                data <= src_data;
        end
    end

endmodule

// File: rtl/signed_div_pow2_pipe.sv
// signed_div_pow2_pipe
// A two-stage valid/ready pipeline that divides a signed N-bit dividend by 2^S.
// It returns the signed quotient and the remainder, where
// remainder = dividend - quotient*2^S (mod 2^N).
//   Stage 1 holds the dividend and the bias-adjusted dividend.
//   Stage 2 holds the quotient and the remainder, and drives the outputs.
// Rounding mode:
//   SIGNED_DIV_POW2_ROUND_ZERO_EN defined   -> round toward zero;
//                                              the remainder takes the dividend's sign
//   SIGNED_DIV_POW2_ROUND_ZERO_EN undefined -> floor; the remainder is in 0..2^S-1
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : dividend handshake; in_ready never depends on in_valid
//   in_data   [N-1:0]    : dividend (two's complement)
//   out_valid/out_ready  : result handshake
//   out_quot  [N-1:0]    : signed quotient
//   out_rem   [N-1:0]    : signed remainder
module signed_div_pow2_pipe
    import signed_div_pow2_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int S = DEF_S
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quot,
    output logic [N-1:0] out_rem
);

`ifdef SIGNED_DIV_POW2_ROUND_ZERO_EN
    localparam bit ROUND_ZERO = 1'b1;
`else
    localparam bit ROUND_ZERO = 1'b0;
`endif

    localparam logic [N-1:0] BIAS     = N'(bias_val(N, S, ROUND_ZERO));
    localparam logic [N-1:0] LOW_MASK = N'((1 << S) - 1);

    logic           s1_load;
    logic           s2_load;
    logic           s1_valid;
    logic           s2_valid;
    logic [N-1:0]   adj_in;
    logic [2*N-1:0] s1_q;
    logic [2*N-1:0] s2_q;
    logic [N-1:0]   s1_div;
    logic [N-1:0]   s1_adj;
    logic [N-1:0]   quot_c;
    logic [N-1:0]   rem_c;

    // A stage loads when it is empty or when the stage after it is taking its item.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Adding a bias of at most 2^S-1 to a negative value stays inside N bits.
    assign adj_in = in_data + (in_data[N-1] ? BIAS : '0);

    div_pow2_reg_slice #(.W(2*N)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (s1_load),
        .src_valid (in_valid),
        .src_data  ({in_data, adj_in}),
        .valid     (s1_valid),
        .data      (s1_q)
    );

    assign {s1_div, s1_adj} = s1_q;

    // Arithmetic shift right by S: replicate the sign bit into the vacated MSBs.
    assign quot_c = {{S{s1_adj[N-1]}}, s1_adj[N-1:S]};

    // quot*2^S mod 2^N equals the adjusted value with its low S bits cleared.
    assign rem_c = s1_div - (s1_adj & ~LOW_MASK);

    div_pow2_reg_slice #(.W(2*N)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (s2_load),
        .src_valid (s1_valid),
        .src_data  ({quot_c, rem_c}),
        .valid     (s2_valid),
        .data      (s2_q)
    );

    assign out_valid           = s2_valid;
    assign {out_quot, out_rem} = s2_q;

endmodule

// File: tb/tb_signed_div_pow2_pipe.sv
// tb_signed_div_pow2_pipe
// Scoreboard bench for signed_div_pow2_pipe (N=8, S=3). Every accepted
// dividend pushes its expected {quot, rem} into a queue, computed with plain
// integer division. A monitor pops the queue and compares on each delivery.
// The rounding mode follows SIGNED_DIV_POW2_ROUND_ZERO_EN.
module tb_signed_div_pow2_pipe;

    localparam int N = 8;
    localparam int S = 3;
`ifdef SIGNED_DIV_POW2_ROUND_ZERO_EN
    localparam bit RZ = 1'b1;
`else
    localparam bit RZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_quot;
    logic [N-1:0] out_rem;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int dlv_cnt = 0;
    logic [2*N-1:0] exp_q[$];
    logic           hold_pending = 1'b0;
    logic [N-1:0]   hold_quot;
    logic [N-1:0]   hold_rem;

    signed_div_pow2_pipe #(.N(N), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed integer division by 2^S, with the rounding mode
    // chosen by the macro.
    function automatic logic [2*N-1:0] ref_model(input logic [N-1:0] d);
        int x;
        int dv;
        int q;
        int r;
        x  = $signed(d);
        dv = 1 << S;
        if (RZ) begin
            q = x / dv;
        end else begin
            r = x % dv;
            if (r < 0) r = r + dv;
            q = (x - r) / dv;
        end
        r = x - q * dv;
        return {q[N-1:0], r[N-1:0]};
    endfunction

    // Scoreboard push/pop and output-hold checking, sampled at the edge with
    // pre-edge values.
    always @(posedge clk) begin
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data));
                acc_cnt <= acc_cnt + 1;
            end
            if (hold_pending) begin
                check("hold_quot", out_quot, hold_quot);
                check("hold_rem", out_rem, hold_rem);
            end
            hold_pending <= out_valid && !out_ready;
            hold_quot    <= out_quot;
            hold_rem     <= out_rem;
            if (out_valid && out_ready) begin
                dlv_cnt <= dlv_cnt + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    logic [2*N-1:0] e;
                    e = exp_q.pop_front();
                    check("quot", out_quot, e[2*N-1:N]);
                    check("rem", out_rem, e[N-1:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            next_cycle();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Pipe must be empty on entry. Checks that out_valid rises exactly two
    // cycles after the item is presented.
    task automatic send_latency(input logic [N-1:0] d);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        check("lat_in_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        check("lat_cycle1_valid", out_valid, 0);
        next_cycle();
        check("lat_cycle2_valid", out_valid, 1);
    endtask

    initial begin
        int a0;
        int d0;
        int cyc;
        logic [N-1:0] dir_vals [6];
        dir_vals = '{8'hF3, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};

        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_quot", out_quot, 0);
        check("rst_rem", out_rem, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        // Directed sign and extreme values, each with a latency check.
        foreach (dir_vals[i]) begin
            send_latency(dir_vals[i]);
            drain();
        end

        // Streaming: 16 back-to-back items, one delivery per cycle.
        out_ready = 1'b1;
        d0 = dlv_cnt;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            check("stream_in_ready", in_ready, 1);
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();
        check("stream_dlv_15", dlv_cnt - d0, 15);
        next_cycle();
        check("stream_dlv_16", dlv_cnt - d0, 16);
        drain();

        // Back-pressure: exactly two accepts, then in_ready drops.
        out_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            next_cycle();
        end
        check("bp_accepts", acc_cnt - a0, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        drain();

        // Reset with two items in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = N'($urandom);
            next_cycle();
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_quot", out_quot, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
        send_latency(8'h08);
        check("post_rst_quot", out_quot, 8'h01);
        check("post_rst_rem", out_rem, 8'h00);
        drain();

        // Random valid/ready with 10k accepted dividends.
        a0  = acc_cnt;
        cyc = 0;
        while (acc_cnt - a0 < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = N'($urandom);
            next_cycle();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_accepts_reached", (acc_cnt - a0 >= 10000) ? 1 : 0, 1);
        drain();
        check("total_balance", dlv_cnt + exp_q.size() <= acc_cnt ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/signed_div_pow2_pipe.md
SIGNED_DIV_POW2_PIPE -- requirements
Module: signed_div_pow2_pipe

Interface
REQ-001 Parameter N, default 8: data width in bits.
REQ-002 Parameter S, default 3: divisor exponent; divisor = 2^S; legal range 1 <= S <= N-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  N  dividend, two's complement.
REQ-008 out_valid  output  1  quotient/remainder pair present.
REQ-009 out_ready  input  1  downstream accepts the pair this cycle.
REQ-010 out_quot  output  N  signed quotient.
REQ-011 out_rem  output  N  signed remainder.

Function
REQ-012 The block SHALL accept a transfer on any rising edge where in_valid && in_ready, and deliver it on any edge where out_valid && out_ready.
REQ-013 The block SHALL implement two register stages: stage 1 holds the dividend and the bias-adjusted value; stage 2 holds the quotient and remainder.
REQ-014 Latency SHALL be exactly 2 cycles from the accept edge to out_valid high, with no stalls.
REQ-015 Throughput SHALL be one result per cycle while out_ready is held high.
REQ-016 Stage 2 SHALL load when it is empty or out_ready is high; stage 1 SHALL load when it is empty or stage 2 loads.
REQ-017 in_ready SHALL equal the stage-1 load condition: combinational from out_ready and the stage valid bits, never from in_valid.
REQ-018 out_quot, out_rem and out_valid SHALL be driven directly from stage-2 registers.
REQ-019 While out_valid && !out_ready, out_quot and out_rem SHALL hold stable.
REQ-020 A full pipe with out_ready low SHALL hold 2 items and drive in_ready low; no item is dropped or duplicated.
REQ-021 With simultaneous accept and deliver on a full pipe, all stages SHALL advance in the same cycle.
REQ-022 The shift SHALL be arithmetic (sign-replicating) and built from slices and concatenation only; the >>> operator is not used.
REQ-023 Remainder SHALL equal in_data - out_quot*2^S, computed modulo 2^N. The bias add on negative inputs cannot overflow N bits, so no extension is required.

Reset
REQ-024 While rst_n is low, both stage valid bits SHALL clear asynchronously: out_valid = 0.
REQ-025 While rst_n is low, in_ready SHALL read 1.
REQ-026 out_quot and out_rem SHALL reset to 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight items; the first accept after release SHALL behave as from idle.

Configuration
REQ-028 With macro SIGNED_DIV_POW2_ROUND_ZERO_EN defined, the quotient SHALL round toward zero (C semantics): negative dividends get a bias of 2^S-1 in stage 1, and the remainder takes the sign of the dividend.
REQ-029 Without SIGNED_DIV_POW2_ROUND_ZERO_EN, the quotient SHALL round toward negative infinity (floor; bias = 0), and the remainder SHALL always be in 0..2^S-1.

Structure
REQ-030 Package signed_div_pow2_pkg SHALL hold the default width/exponent localparams and a function returning the bias value for given N and S.
REQ-031 One sub-module, div_pow2_reg_slice, SHALL be used: a parameterised valid/ready register stage instantiated twice.
REQ-032 Bias and shift logic SHALL reside in the top module.

Verification (N=8, S=3)
REQ-033 Sign rounding: in_data 0xF3 (-13) -> ROUND_ZERO_EN: quot 0xFF (-1), rem 0xFB (-5); floor: quot 0xFE (-2), rem 0x03.
REQ-034 Extremes: 0x80 (-128) -> quot 0xF0, rem 0x00 in both modes. 0x7F (127) -> quot 0x0F, rem 0x07.
REQ-035 Streaming: 16 back-to-back inputs with out_ready=1 -> first out_valid 2 cycles after first accept; 16 consecutive results in order.
REQ-036 Back-pressure: out_ready=0 for 5 cycles, in_valid=1 throughout -> exactly 2 accepts, then in_ready=0. Releasing out_ready yields ordered outputs with none lost.
REQ-037 Reset mid-stream: rst_n low with 2 items in flight -> out_valid=0 asynchronously. After release, the next input 0x08 -> quot 0x01, rem 0x00 at latency 2.
REQ-038 Random compare: 10k random in_data with random in_valid/out_ready -> every pair matches a reference model for the compiled rounding mode.
